// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares a single-read/single-write register file between requesters A and B.
// Define REGARB_RR_EN for round-robin tie breaking; otherwise ties go to A.
module regfile_arbiter #(
  parameter int DW = 32,
  parameter int AW = 2
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          A_Req,
  input  logic          A_Wr,
  input  logic [AW-1:0] A_Addr,
  input  logic [DW-1:0] A_WData,
  output logic          A_Ack,
  output logic [DW-1:0] A_RData,
  input  logic          B_Req,
  input  logic          B_Wr,
  input  logic [AW-1:0] B_Addr,
  input  logic [DW-1:0] B_WData,
  output logic          B_Ack,
  output logic [DW-1:0] B_RData,
  output logic          RF_Ren,
  output logic          RF_Wen,
  output logic [AW-1:0] RF_RAddr,
  output logic [AW-1:0] RF_WAddr,
  output logic [DW-1:0] RF_WData,
  output logic          RF_Rst,
  input  logic [DW-1:0] RF_RData,
  output logic          Busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, DONE} state_t;
  state_t        state_q, state_d;
  logic          gnt_b_q, gnt_b_d;
  logic          last_b_q, last_b_d;
  logic          cmd_wr_q, cmd_wr_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic          ren_q, ren_d, wen_q, wen_d;
  logic          a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic          busy_q, busy_d;
  logic          pick_b;
  always_comb begin
`ifdef REGARB_RR_EN
    pick_b = B_Req && (!A_Req || !last_b_q);
`else
    pick_b = !A_Req;
`endif
    state_d     = state_q;
    gnt_b_d     = gnt_b_q;
    last_b_d    = last_b_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    case (state_q)
      IDLE: if (A_Req || B_Req) begin
        state_d     = ISSUE;
        gnt_b_d     = pick_b;
        last_b_d    = pick_b;
        cmd_wr_d    = pick_b ? B_Wr : A_Wr;
        cmd_addr_d  = pick_b ? B_Addr : A_Addr;
        cmd_wdata_d = pick_b ? B_WData : A_WData;
      end
      ISSUE: state_d = cmd_wr_q ? DONE : RWAIT;
      RWAIT: begin
        state_d   = DONE;
        a_rdata_d = gnt_b_q ? a_rdata_q : RF_RData;
        b_rdata_d = gnt_b_q ? RF_RData : b_rdata_q;
      end
      default: state_d = IDLE;
    endcase
    // Strobes are decoded from the next state so they come straight off flops
    wen_d   = (state_d == ISSUE) && cmd_wr_d;
    ren_d   = (state_d == ISSUE) && !cmd_wr_d;
    a_ack_d = (state_d == DONE) && !gnt_b_d;
    b_ack_d = (state_d == DONE) && gnt_b_d;
    busy_d  = state_d != IDLE;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      gnt_b_q     <= 1'b0;
      last_b_q    <= 1'b1;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_b_q     <= gnt_b_d;
      last_b_q    <= last_b_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      ren_q       <= ren_d;
      wen_q       <= wen_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      busy_q      <= busy_d;
    end
  end
  assign A_Ack    = a_ack_q;
  assign B_Ack    = b_ack_q;
  assign A_RData  = a_rdata_q;
  assign B_RData  = b_rdata_q;
  assign RF_Ren   = ren_q;
  assign RF_Wen   = wen_q;
  assign RF_RAddr = cmd_addr_q;
  assign RF_WAddr = cmd_addr_q;
  assign RF_WData = cmd_wdata_q;
  assign RF_Rst   = ~Rst_n;
  assign Busy     = busy_q;
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: randomized two-requester traffic against a transaction-level model.
module tb_regfile_arbiter;
`ifdef REGARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        A_Req = 0, A_Wr = 0, B_Req = 0, B_Wr = 0;
  logic [1:0]  A_Addr = 0, B_Addr = 0;
  logic [31:0] A_WData = 0, B_WData = 0;
  logic        A_Ack, B_Ack, RF_Ren, RF_Wen, RF_Rst, Busy;
  logic [31:0] A_RData, B_RData, RF_WData, RF_RData;
  logic [1:0]  RF_RAddr, RF_WAddr;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] rf_mem [4];
  logic [31:0] mem [4];
  logic [31:0] exp_a_rdata = 0, exp_b_rdata = 0;
  logic        last_b = 1'b1;

  regfile_arbiter dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .A_Req(A_Req), .A_Wr(A_Wr), .A_Addr(A_Addr), .A_WData(A_WData), .A_Ack(A_Ack), .A_RData(A_RData),
    .B_Req(B_Req), .B_Wr(B_Wr), .B_Addr(B_Addr), .B_WData(B_WData), .B_Ack(B_Ack), .B_RData(B_RData),
    .RF_Ren(RF_Ren), .RF_Wen(RF_Wen), .RF_RAddr(RF_RAddr), .RF_WAddr(RF_WAddr), .RF_WData(RF_WData),
    .RF_Rst(RF_Rst), .RF_RData(RF_RData), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // register file with a registered read port
  always @(posedge Clk or posedge RF_Rst) begin
    if (RF_Rst) begin
      for (int i = 0; i < 4; i++) rf_mem[i] <= '0;
      RF_RData <= '0;
    end else begin
      if (RF_Wen) rf_mem[RF_WAddr] <= RF_WData;
      if (RF_Ren) RF_RData <= rf_mem[RF_RAddr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mem[i] = '0;
    exp_a_rdata = '0;
    exp_b_rdata = '0;
    last_b = 1'b1;
  endtask

  // One round: chosen requesters raise Req together and each holds it until its own Ack.
  task automatic run_round(input logic ra, input logic rb, input logic wa, input logic wb,
                           input logic [1:0] aa, input logic [1:0] ab,
                           input logic [31:0] da, input logic [31:0] db);
    logic win_b;
    int la, lb, ka, kb, ia, ib, kmax;
    win_b = (ra && rb) ? (RR ? !last_b : 1'b0) : rb;
    la = wa ? 2 : 3;
    lb = wb ? 2 : 3;
    ka = 0; kb = 0; ia = 0; ib = 0;
    if (ra && !rb) begin ka = la; ia = 1; end
    else if (rb && !ra) begin kb = lb; ib = 1; end
    else if (win_b) begin kb = lb; ib = 1; ia = lb + 2; ka = lb + 1 + la; end
    else begin ka = la; ia = 1; ib = la + 2; kb = la + 1 + lb; end
    last_b = (ra && rb) ? !win_b : rb;
    kmax = (ka > kb ? ka : kb) + 1;
    A_Req = ra; A_Wr = wa; A_Addr = aa; A_WData = da;
    B_Req = rb; B_Wr = wb; B_Addr = ab; B_WData = db;
    for (int k = 1; k <= kmax; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (k == 1) begin
        check("busy", Busy, 1);
        if (win_b) begin B_Addr = ~ab; B_WData = ~db; B_Wr = !wb; end
        else if (ra) begin A_Addr = ~aa; A_WData = ~da; A_Wr = !wa; end
      end
      if (k == ia) begin
        check("a_wen", RF_Wen, wa);
        check("a_ren", RF_Ren, !wa);
        check(wa ? "a_waddr" : "a_raddr", wa ? RF_WAddr : RF_RAddr, aa);
        if (wa) check("a_wdata", RF_WData, da);
      end else if (k == ib) begin
        check("b_wen", RF_Wen, wb);
        check("b_ren", RF_Ren, !wb);
        check(wb ? "b_waddr" : "b_raddr", wb ? RF_WAddr : RF_RAddr, ab);
        if (wb) check("b_wdata", RF_WData, db);
      end else begin
        check("wen_idle", RF_Wen, 0);
        check("ren_idle", RF_Ren, 0);
      end
      check("a_ack", A_Ack, k == ka);
      check("b_ack", B_Ack, k == kb);
      if (k == ka) begin
        if (wa) mem[aa] = da; else exp_a_rdata = mem[aa];
        A_Req = 0;
        check("a_rdata", A_RData, exp_a_rdata);
        check("b_rdata_hold", B_RData, exp_b_rdata);
      end
      if (k == kb) begin
        if (wb) mem[ab] = db; else exp_b_rdata = mem[ab];
        B_Req = 0;
        check("b_rdata", B_RData, exp_b_rdata);
        check("a_rdata_hold", A_RData, exp_a_rdata);
      end
    end
    check("busy_end", Busy, 0);
  endtask

  initial begin
    logic exp_g;
    logic grants [$];
    int cyc;
    model_reset();
    #1;
    check("rst_rf_rst", RF_Rst, 1);
    check("rst_busy", Busy, 0);
    check("rst_ack", {A_Ack, B_Ack, RF_Wen, RF_Ren}, 0);
    check("rst_rdata", A_RData | B_RData, 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("rf_rst_off", RF_Rst, 0);

    run_round(1, 0, 1, 0, 2'd0, 2'd0, 32'd15, 32'd0);
    run_round(1, 0, 1, 0, 2'd1, 2'd0, 32'd103, 32'd0);
    run_round(1, 0, 0, 0, 2'd1, 2'd0, 32'd0, 32'd0);
    run_round(1, 1, 1, 0, 2'd2, 2'd0, 32'd34, 32'd0);

    for (int r = 0; r < 40; r++) begin
      logic [1:0] who;
      who = 2'($urandom_range(1, 3));
      run_round(who[0], who[1], 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                $urandom, $urandom);
    end

    // both requesters hold Req across four back-to-back transactions
    A_Req = 1; A_Wr = 1; A_Addr = 3; A_WData = 32'haaaa_0001;
    B_Req = 1; B_Wr = 1; B_Addr = 3; B_WData = 32'hbbbb_0002;
    cyc = 0;
    while (grants.size() < 4 && cyc < 40) begin
      @(posedge Clk);
      @(negedge Clk);
      cyc++;
      if (A_Ack) begin grants.push_back(1'b0); mem[3] = A_WData; end
      if (B_Ack) begin grants.push_back(1'b1); mem[3] = B_WData; end
    end
    A_Req = 0; B_Req = 0;
    check("held_count", grants.size(), 4);
    foreach (grants[i]) begin
      exp_g = RR ? !last_b : 1'b0;
      last_b = exp_g;
      check("held_grant", grants[i], exp_g);
    end
    repeat (2) @(negedge Clk);
    check("held_idle", Busy, 0);
    run_round(1, 0, 0, 0, 2'd3, 2'd0, 32'd0, 32'd0);

    // reset lands while B's read is waiting on regfile data
    B_Req = 1; B_Wr = 0; B_Addr = 0;
    repeat (2) begin @(posedge Clk); @(negedge Clk); end
    check("pre_rst_busy", Busy, 1);
    Rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_rf_rst", RF_Rst, 1);
    check("mid_rst_strobes", {A_Ack, B_Ack, RF_Wen, RF_Ren, Busy}, 0);
    check("mid_rst_a_rdata", A_RData, 0);
    check("mid_rst_b_rdata", B_RData, 0);
    check("mid_rst_addr", {RF_WAddr, RF_RAddr}, 0);
    check("mid_rst_wdata", RF_WData, 0);
    B_Req = 0;
    repeat (3) begin
      @(posedge Clk);
      @(negedge Clk);
      check("mid_rst_no_ack", B_Ack, 0);
    end
    Rst_n = 1'b1;
    repeat (2) begin
      @(posedge Clk);
      @(negedge Clk);
      check("post_rst_no_ack", {A_Ack, B_Ack}, 0);
    end
    run_round(1, 0, 0, 0, 2'd2, 2'd0, 32'd0, 32'd0);
    run_round(0, 1, 0, 0, 2'd0, 2'd1, 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
